// File: rtl/hc138_rr_sched_if.sv
// hc138_rr_sched_if: request/decoder-control bundle between requesters and the 74HC138 scheduler
//   en, req             : scheduler enable and request vector (driven by master)
//   DataIn, G1, G2AN,
//   G2BN                : 74HC138 select code and enable pins (driven by slave)
//   gnt, busy, timeout  : one-hot grant mirror, activity flag, timeout pulse (driven by slave)
interface hc138_rr_sched_if;
    logic       en;
    logic [7:0] req;
    logic [2:0] DataIn;
    logic       G1;
    logic       G2AN;
    logic       G2BN;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (
        output en, req,
        input  DataIn, G1, G2AN, G2BN, gnt, busy, timeout
    );

    modport slave (
        input  en, req,
        output DataIn, G1, G2AN, G2BN, gnt, busy, timeout
    );
endinterface

// File: rtl/hc138_rr_sched.sv
// hc138_rr_sched: round-robin scheduler driving a 74HC138 decoder with a break-before-make gap
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-high
//   bus      : hc138_rr_sched_if.slave (en/req in; DataIn/G1/G2AN/G2BN/gnt/busy/timeout out)
//   HOLD_MAX : maximum grant length in cycles (1..255), used only with HC138_RR_TIMEOUT_EN
//   Macro HC138_RR_TIMEOUT_EN: when defined, grants are revoked after HOLD_MAX cycles
//   and timeout pulses in the following GAP cycle; otherwise timeout is tied low.
module hc138_rr_sched #(
    parameter int HOLD_MAX = 16
) (
    input logic             clk,
    input logic             rst,
    hc138_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, code, code_n, win, idx;
    logic [7:0] gnt_q;
    logic       g1_q, g2an_q, g2bn_q, busy_q, hold_end;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_chk
        $error("HOLD_MAX must lie in 1..255");
    end

    // Scan from ptr+7 down to ptr so the lowest rotated offset is the last writer and wins.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (bus.req[idx]) win = idx;
        end
    end

    // IDLE and GAP arbitrate identically; GAP differs only in having been entered from GRANT.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        code_n  = code;
        if (state == GRANT) begin
            state_n = (!bus.req[code] || !bus.en || hold_end) ? GAP : GRANT;
        end else if (bus.en && |bus.req) begin
            state_n = GRANT;
            code_n  = win;
            ptr_n   = win + 3'd1;
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            code   <= '0;
            gnt_q  <= '0;
            g1_q   <= 1'b0;
            g2an_q <= 1'b1;
            g2bn_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            code   <= code_n;
            gnt_q  <= (state_n == GRANT) ? 8'd1 << code_n : 8'd0;
            g1_q   <= state_n == GRANT;
            g2an_q <= state_n != GRANT;
            g2bn_q <= state_n != GRANT;
            busy_q <= state_n != IDLE;
        end
    end

`ifdef HC138_RR_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt, cnt_n;
    logic       to_q, to_n;

    assign hold_end = cnt == HOLD_LAST;

    // A simultaneous release or disable takes precedence, so only a still-wanted grant times out.
    always_comb begin
        cnt_n = (state_n == GRANT && state != GRANT) ? 8'd0 :
                (state == GRANT && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
        to_n  = state == GRANT && bus.en && bus.req[code] && hold_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            to_q <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            to_q <= to_n;
        end
    end

    assign bus.timeout = to_q;
`else
    assign hold_end    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.DataIn = code;
    assign bus.G1     = g1_q;
    assign bus.G2AN   = g2an_q;
    assign bus.G2BN   = g2bn_q;
    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
endmodule
